key_action_scheduler: RTL and testbench

- Sits between the PS/2 keyboard decoder (key1/2/3_on and key1/2/3_code) and the Tetris game core.
- Turns the three held-key channels into a single stream of one-shot game actions over a valid/ready handshake.
- Applies Tetris repeat timing: DAS/ARR auto-shift for left/right and a fast repeat for soft drop.
- Round-robin arbitration decides which channel's action goes next.

---
 rtl/key_action_pkg.sv | 67 ++++++
 rtl/key_repeat_channel.sv | 163 ++++++++++++++++
 rtl/key_action_scheduler.sv | 116 +++++++++++
 tb/tb_key_action_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_action_pkg.sv
// Shared scan codes, action encoding and decode helpers for the key-to-action scheduler.
package key_action_pkg;

    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_Z        = 8'h1A;
    localparam logic [7:0] SC_X        = 8'h22;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_C        = 8'h21;

    localparam int unsigned CHAN_N     = 32'd3;

    typedef enum logic [2:0] {
        ACT_START     = 3'd0,
        ACT_LEFT      = 3'd1,
        ACT_RIGHT     = 3'd2,
        ACT_SOFT_DROP = 3'd3,
        ACT_ROT_CW    = 3'd4,
        ACT_ROT_CCW   = 3'd5,
        ACT_HARD_DROP = 3'd6,
        ACT_HOLD      = 3'd7
    } action_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_DAS    = 2'd2,
        ST_REPEAT = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic    valid;
        action_e act;
    } decode_t;

    function automatic decode_t code_to_action(input logic [7:0] code);
        decode_t d;
        d.valid = 1'b1;
        case (code)
            SC_LEFT:      d.act = ACT_LEFT;
            SC_RIGHT:     d.act = ACT_RIGHT;
            SC_DOWN:      d.act = ACT_SOFT_DROP;
            SC_X, SC_UP:  d.act = ACT_ROT_CW;
            SC_Z:         d.act = ACT_ROT_CCW;
            SC_LSHIFT:    d.act = ACT_HARD_DROP;
            SC_C:         d.act = ACT_HOLD;
            SC_ENTER:     d.act = ACT_START;
            default: begin
                d.valid = 1'b0;
                d.act   = ACT_START;
            end
        endcase
        return d;
    endfunction

    function automatic logic is_repeatable(input action_e act);
        return (act == ACT_LEFT) || (act == ACT_RIGHT) || (act == ACT_SOFT_DROP);
    endfunction

    function automatic logic [1:0] next_chan(input logic [1:0] chan);
        return (chan == 2'd2) ? 2'd0 : chan + 2'd1;
    endfunction

endpackage

// File: rtl/key_repeat_channel.sv
// One held-key channel: synchroniser, scan-code capture, DAS/ARR repeat FSM and a
// single-entry pending action flag.
module key_repeat_channel
    import key_action_pkg::*;
#(
    parameter int unsigned DAS_CYC   = 32'd8000000,
    parameter int unsigned ARR_CYC   = 32'd2500000,
    parameter int unsigned SDROP_CYC = 32'd1250000,
    parameter int unsigned CNT_W     = 32'd24
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       key_on_i,
    input  logic [7:0] key_code_i,
    input  logic       enable_i,
    input  logic       grant_i,
    output logic       pending_o,
    output logic [2:0] action_o,
    output logic       repeat_o,
    output logic       on_sync_o
);

    localparam logic [CNT_W-1:0] DAS_LD   = CNT_W'(DAS_CYC);
    localparam logic [CNT_W-1:0] ARR_LD   = CNT_W'(ARR_CYC);
    localparam logic [CNT_W-1:0] SDROP_LD = CNT_W'(SDROP_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic             on_s1_q, on_s2_q, on_prev_q;
    logic [7:0]       code_s1_q, code_s2_q;
    logic [1:0]       fill_q;
    logic [7:0]       code_q, code_d;
    logic             lock_q, lock_d;
    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    action_e          act_q, act_d;
    logic             pend_q, pend_d, rep_q, rep_d;
    logic             press_s, first_s, tick_s;
    logic [CNT_W-1:0] period_s;
    decode_t          dec_s;

    // Two-flop synchronisers and a record of how far the pipeline has filled since reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            on_s1_q   <= 1'b0;
            on_s2_q   <= 1'b0;
            on_prev_q <= 1'b0;
            code_s1_q <= 8'h00;
            code_s2_q <= 8'h00;
            fill_q    <= 2'b00;
        end else begin
            on_s1_q   <= key_on_i;
            on_s2_q   <= on_s1_q;
            on_prev_q <= on_s2_q;
            code_s1_q <= key_code_i;
            code_s2_q <= code_s1_q;
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

    // A key already held when reset releases stays locked out until it is seen released
    always_comb begin
        dec_s    = code_to_action(code_s2_q);
        press_s  = !lock_q && on_s2_q && (!on_prev_q || (code_s2_q != code_q));
        lock_d   = lock_q && !(fill_q[1] && !on_s2_q);
        code_d   = press_s ? code_s2_q : code_q;
        period_s = (act_q == ACT_SOFT_DROP) ? SDROP_LD : ARR_LD;
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        first_s  = 1'b0;
        tick_s   = 1'b0;
        if (!on_s2_q || lock_q) begin
            state_d = ST_IDLE;
        end else if (press_s) begin
            if (enable_i && dec_s.valid) begin
                state_d = ST_FIRST;
                act_d   = dec_s.act;
                first_s = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (!enable_i) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_FIRST: begin
                    if (act_q == ACT_SOFT_DROP) begin
                        cnt_d   = SDROP_LD;
                        state_d = ST_REPEAT;
                    end else if (is_repeatable(act_q)) begin
                        cnt_d   = DAS_LD;
                        state_d = ST_DAS;
                    end else begin
                        state_d = ST_FIRST;
                    end
                end
                ST_DAS: begin
                    if (cnt_q == CNT_ONE) begin
                        tick_s  = 1'b1;
                        cnt_d   = ARR_LD;
                        state_d = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (cnt_q == CNT_ONE) begin
                        tick_s = 1'b1;
                        cnt_d  = period_s;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pending flag: a set beats a same-cycle grant; a tick is dropped only if the flag survives
    always_comb begin
        pend_d = pend_q;
        rep_d  = rep_q;
        if (first_s) begin
            pend_d = 1'b1;
            rep_d  = 1'b0;
        end else if (tick_s && (!pend_q || grant_i)) begin
            pend_d = 1'b1;
            rep_d  = 1'b1;
        end else if (grant_i || !enable_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Channel state, repeat counter, captured code and pending action
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            act_q   <= ACT_START;
            code_q  <= 8'h00;
            lock_q  <= 1'b1;
            pend_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            code_q  <= code_d;
            lock_q  <= lock_d;
            pend_q  <= pend_d;
            rep_q   <= rep_d;
        end
    end

    assign pending_o = pend_q;
    assign action_o  = act_q;
    assign repeat_o  = rep_q;
    assign on_sync_o = on_s2_q;

endmodule

// File: rtl/key_action_scheduler.sv
// Three held-key channels merged into one valid/ready action stream by a
// round-robin arbiter feeding a single output register.
module key_action_scheduler
    import key_action_pkg::*;
#(
    parameter int unsigned DAS_CYC   = 32'd8000000,
    parameter int unsigned ARR_CYC   = 32'd2500000,
    parameter int unsigned SDROP_CYC = 32'd1250000,
    parameter int unsigned CNT_W     = 32'd24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1_on,
    input  logic       key2_on,
    input  logic       key3_on,
    input  logic [7:0] key1_code,
    input  logic [7:0] key2_code,
    input  logic [7:0] key3_code,
    input  logic       game_enable,
    input  logic       act_ready,
    output logic       act_valid,
    output logic [2:0] act_code,
    output logic       act_repeat,
    output logic [2:0] chan_active
);

    logic [2:0] key_on_s;
    logic [7:0] key_code_s [CHAN_N];
    logic [2:0] pend_s, rep_s, grant_s, on_s;
    logic [2:0] chan_act_s [CHAN_N];
    logic       valid_q, valid_d, rep_q, rep_d;
    logic [2:0] code_q, code_d;
    logic [1:0] ptr_q, ptr_d, cand_s, win_s;
    logic       found_s, load_s;

    assign key_on_s      = {key3_on, key2_on, key1_on};
    assign key_code_s[0] = key1_code;
    assign key_code_s[1] = key2_code;
    assign key_code_s[2] = key3_code;

    for (genvar g = 0; g < CHAN_N; g++) begin : g_chan
        key_repeat_channel #(
            .DAS_CYC   (DAS_CYC),
            .ARR_CYC   (ARR_CYC),
            .SDROP_CYC (SDROP_CYC),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk_i      (clk),
            .rst_ni     (rst),
            .key_on_i   (key_on_s[g]),
            .key_code_i (key_code_s[g]),
            .enable_i   (game_enable),
            .grant_i    (grant_s[g]),
            .pending_o  (pend_s[g]),
            .action_o   (chan_act_s[g]),
            .repeat_o   (rep_s[g]),
            .on_sync_o  (on_s[g])
        );
    end

    // Round-robin pick from the pointer; output register refills when empty or just accepted
    always_comb begin
        load_s  = !valid_q || act_ready;
        found_s = 1'b0;
        win_s   = 2'd0;
        cand_s  = ptr_q;
        grant_s = 3'b000;
        valid_d = valid_q;
        code_d  = code_q;
        rep_d   = rep_q;
        ptr_d   = ptr_q;
        for (int k = 0; k < CHAN_N; k++) begin
            if (!found_s && pend_s[cand_s] && game_enable) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
            cand_s = next_chan(cand_s);
        end
        if (load_s) begin
            if (found_s) begin
                valid_d        = 1'b1;
                code_d         = chan_act_s[win_s];
                rep_d          = rep_s[win_s];
                grant_s[win_s] = 1'b1;
                ptr_d          = next_chan(win_s);
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            rep_q   <= 1'b0;
            ptr_q   <= 2'd0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            rep_q   <= rep_d;
            ptr_q   <= ptr_d;
        end
    end

    assign act_valid   = valid_q;
    assign act_code    = code_q;
    assign act_repeat  = rep_q;
    assign chan_active = on_s;

endmodule

// File: tb/tb_key_action_scheduler.sv
// Directed bench for key_action_scheduler with short repeat periods
// (DAS 10, ARR 4, soft-drop 2); expected edges and codes are hand-derived.
module tb_key_action_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key1_on = 1'b0, key2_on = 1'b0, key3_on = 1'b0;
    logic [7:0] key1_code = 8'h00, key2_code = 8'h00, key3_code = 8'h00;
    logic       game_enable = 1'b1;
    logic       act_ready = 1'b1;
    logic       act_valid;
    logic [2:0] act_code;
    logic       act_repeat;
    logic [2:0] chan_active;

    int nrun = 0;
    int nfail = 0;
    int cyc = 0;
    int c0, c1;
    int q_edge[$];
    int q_code[$];
    int q_rep[$];

    key_action_scheduler #(
        .DAS_CYC(10), .ARR_CYC(4), .SDROP_CYC(2), .CNT_W(24)
    ) dut (
        .clk(clk), .rst(rst),
        .key1_on(key1_on), .key2_on(key2_on), .key3_on(key3_on),
        .key1_code(key1_code), .key2_code(key2_code), .key3_code(key3_code),
        .game_enable(game_enable), .act_ready(act_ready),
        .act_valid(act_valid), .act_code(act_code), .act_repeat(act_repeat),
        .chan_active(chan_active)
    );

    always #5 clk = ~clk;

    // Log every accepted action with the number of the edge that accepted it
    always @(posedge clk) begin
        if (act_valid && act_ready) begin
            q_edge.push_back(cyc + 1);
            q_code.push_back(int'(act_code));
            q_rep.push_back(int'(act_repeat));
        end
        cyc <= cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        q_edge.delete();
        q_code.delete();
        q_rep.delete();
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        nrun++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input int i, input int base,
                             input int off, input int code, input int rep);
        if (i < q_edge.size()) begin
            check({tag, "_edge"}, q_edge[i] - base, off);
            check({tag, "_code"}, q_code[i], code);
            check({tag, "_rep"}, q_rep[i], rep);
        end else begin
            check({tag, "_missing"}, q_edge.size(), i + 1);
        end
    endtask

    initial begin
        step(3);
        check("rst_valid", int'(act_valid), 0);
        check("rst_code", int'(act_code), 0);
        check("rst_repeat", int'(act_repeat), 0);
        check("rst_chan", int'(chan_active), 0);
        rst = 1'b1;
        step(5);

        // START is one-shot: one action at edge 4, nothing while held
        clear_log(); c0 = cyc;
        key1_code = 8'h5A; key1_on = 1'b1;
        step(3);
        check("start_lat3", int'(act_valid), 0);
        step(1);
        check("start_valid", int'(act_valid), 1);
        check("start_code", int'(act_code), 0);
        check("start_rep", int'(act_repeat), 0);
        check("start_chan", int'(chan_active), 1);
        step(46); key1_on = 1'b0; step(10);
        check("start_count", q_edge.size(), 1);
        chk_entry("start0", 0, c0, 5, 0, 0);

        // LEFT held 30 cycles: DAS then ARR repeats, none after release
        clear_log(); c0 = cyc;
        key1_code = 8'h6B; key1_on = 1'b1;
        step(30); key1_on = 1'b0; step(20);
        check("left_count", q_edge.size(), 6);
        chk_entry("left0", 0, c0, 5, 1, 0);
        chk_entry("left1", 1, c0, 16, 1, 1);
        chk_entry("left2", 2, c0, 20, 1, 1);
        chk_entry("left5", 5, c0, 32, 1, 1);

        rst = 1'b0; step(2); rst = 1'b1; step(5);

        // Three channels at once: served 1,2,3 back to back
        clear_log(); c0 = cyc;
        key1_code = 8'h74; key2_code = 8'h22; key3_code = 8'h72;
        key1_on = 1'b1; key2_on = 1'b1; key3_on = 1'b1;
        step(4);
        key1_on = 1'b0; key2_on = 1'b0; key3_on = 1'b0;
        step(20);
        check("rr_count", q_edge.size(), 4);
        chk_entry("rr0", 0, c0, 5, 2, 0);
        chk_entry("rr1", 1, c0, 6, 4, 0);
        chk_entry("rr2", 2, c0, 7, 3, 0);
        chk_entry("rr3", 3, c0, 8, 3, 1);

        // Pointer back at channel 1: channel 1 beats channel 2
        clear_log(); c0 = cyc;
        key1_code = 8'h12; key2_code = 8'h1A;
        key1_on = 1'b1; key2_on = 1'b1;
        step(4);
        key1_on = 1'b0; key2_on = 1'b0;
        step(10);
        check("ptr_count", q_edge.size(), 2);
        chk_entry("ptr0", 0, c0, 5, 6, 0);
        chk_entry("ptr1", 1, c0, 6, 5, 0);

        // Backpressure on SOFT_DROP: stable output, one collapsed repeat
        clear_log(); c0 = cyc;
        act_ready = 1'b0;
        key1_code = 8'h72; key1_on = 1'b1;
        step(5);
        check("bp_valid5", int'(act_valid), 1);
        check("bp_code5", int'(act_code), 3);
        step(7);
        check("bp_code12", int'(act_code), 3);
        step(3); key1_on = 1'b0;
        step(4);
        check("bp_valid19", int'(act_valid), 1);
        check("bp_code19", int'(act_code), 3);
        check("bp_rep19", int'(act_repeat), 0);
        step(1); act_ready = 1'b1;
        step(10);
        check("bp_count", q_edge.size(), 2);
        chk_entry("bp0", 0, c0, 21, 3, 0);
        chk_entry("bp1", 1, c0, 22, 3, 1);

        // Short HOLD tap while output is blocked is still delivered
        clear_log(); c0 = cyc;
        act_ready = 1'b0;
        key2_code = 8'h5A; key2_on = 1'b1;
        step(3); key2_on = 1'b0;
        step(2); key1_code = 8'h21; key1_on = 1'b1;
        step(2); key1_on = 1'b0;
        step(5);
        check("tap_hold_valid", int'(act_valid), 1);
        check("tap_hold_code", int'(act_code), 0);
        act_ready = 1'b1;
        step(10);
        check("tap_count", q_edge.size(), 2);
        chk_entry("tap0", 0, c0, 13, 0, 0);
        chk_entry("tap1", 1, c0, 14, 7, 0);

        // Press while disabled never fires; unknown code never fires
        clear_log();
        game_enable = 1'b0;
        key2_code = 8'h12; key2_on = 1'b1;
        step(10); game_enable = 1'b1;
        step(15); key2_on = 1'b0;
        key3_code = 8'h00; key3_on = 1'b1;
        step(10); key3_on = 1'b0;
        step(5);
        check("dis_count", q_edge.size(), 0);
        c1 = cyc;
        key2_on = 1'b1;
        step(4);
        check("en_valid", int'(act_valid), 1);
        check("en_code", int'(act_code), 6);
        key2_on = 1'b0;
        step(10);

        // Reset during DAS with a pending output: immediate clear, held key ignored
        clear_log(); c0 = cyc;
        act_ready = 1'b0;
        key1_code = 8'h6B; key1_on = 1'b1;
        step(8);
        check("mid_valid", int'(act_valid), 1);
        check("mid_code", int'(act_code), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", int'(act_valid), 0);
        check("mid_rst_code", int'(act_code), 0);
        check("mid_rst_rep", int'(act_repeat), 0);
        check("mid_rst_chan", int'(chan_active), 0);
        step(2); rst = 1'b1; act_ready = 1'b1;
        step(40);
        check("held_count", q_edge.size(), 0);
        check("held_chan", int'(chan_active), 1);
        key1_on = 1'b0;
        step(6);
        c1 = cyc;
        key1_on = 1'b1;
        step(3);
        check("repress_lat3", int'(act_valid), 0);
        step(1);
        check("repress_valid", int'(act_valid), 1);
        check("repress_code", int'(act_code), 1);
        check("repress_rep", int'(act_repeat), 0);
        key1_on = 1'b0;
        step(10);

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
